// File: rtl/easy_timer_seq.sv
// easy_timer_seq: drives configuration, acknowledge, halt and snapshot accesses to a memory-mapped timer.
// Optional snapshot readout is built when EASY_TIMER_SEQ_SNAPSHOT_EN is defined.
module easy_timer_seq #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              stop_req,
    input  logic              snap_req,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_STOP     = 4'd1,
        S_WR_PL    = 4'd2,
        S_WR_PH    = 4'd3,
        S_START    = 4'd4,
        S_RUN      = 4'd5,
        S_ACK      = 4'd6,
        S_HALT     = 4'd7,
        S_CLR      = 4'd8
`ifdef EASY_TIMER_SEQ_SNAPSHOT_EN
        ,
        S_SNAP_W   = 4'd9,
        S_SNAP_RL  = 4'd10,
        S_SNAP_RH  = 4'd11,
        S_SNAP_CAP = 4'd12
`endif
    } state_t;

    localparam logic [2:0]  A_STATUS   = 3'd0;
    localparam logic [2:0]  A_CONTROL  = 3'd1;
    localparam logic [2:0]  A_PERIOD_L = 3'd2;
    localparam logic [2:0]  A_PERIOD_H = 3'd3;
`ifdef EASY_TIMER_SEQ_SNAPSHOT_EN
    localparam logic [2:0]  A_SNAP_L   = 3'd4;
    localparam logic [2:0]  A_SNAP_H   = 3'd5;
`endif
    localparam logic [15:0] CTRL_STOP  = 16'h0008;
    localparam logic [15:0] CTRL_START = 16'h0005;
    localparam logic [15:0] CTRL_CONT  = 16'h0002;

    state_t              state_q, state_d;
    logic [31:0]         period_q, period_d;
    logic                cont_q, cont_d;
    logic                stop_pend_q, stop_pend_d;
    logic                snap_pend_q, snap_pend_d;
    logic                ret_run_q, ret_run_d;
    logic [15:0]         snap_lo_q, snap_lo_d;
    logic [31:0]         snap_value_q, snap_value_d;
    logic                snap_valid_q, snap_valid_d;
    logic                tick_q, tick_d;
    logic [TICK_W-1:0]   tick_count_q, tick_count_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                busy_q, busy_d;
    logic [2:0]          addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                wn_q, wn_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                snap_req_s;
    logic                stop_ignore_s;

`ifdef EASY_TIMER_SEQ_SNAPSHOT_EN
    assign snap_req_s = snap_req;
`else
    logic unused_snap_s;
    assign snap_req_s    = 1'b0;
    assign unused_snap_s = ^{snap_req, tmr_readdata};
`endif

    // Next-state, bookkeeping and registered bus-output decode for the sequencer.
    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        cont_d        = cont_q;
        ret_run_d     = ret_run_q;
        snap_lo_d     = snap_lo_q;
        snap_value_d  = snap_value_q;
        snap_valid_d  = 1'b0;
        tick_d        = 1'b0;
        tick_count_d  = tick_count_q;
        // Requests that cannot be acted on immediately are remembered; the
        // branches that service them clear the pending bit below.
        stop_ignore_s = state_q inside {S_IDLE, S_STOP, S_WR_PL, S_WR_PH, S_START, S_HALT, S_CLR};
        stop_pend_d   = stop_pend_q | (stop_req & ~stop_ignore_s);
        snap_pend_d   = snap_pend_q | snap_req_s;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    state_d      = S_STOP;
                    period_d     = cfg_period;
                    cont_d       = cfg_continuous;
                    tick_count_d = {TICK_W{1'b0}};
                    stop_pend_d  = 1'b0;
                end
`ifdef EASY_TIMER_SEQ_SNAPSHOT_EN
                else if (snap_req_s || snap_pend_q) begin
                    state_d     = S_SNAP_W;
                    ret_run_d   = 1'b0;
                    snap_pend_d = 1'b0;
                end
`endif
                else begin
                    state_d = S_IDLE;
                end
            end
            S_STOP:  state_d = S_WR_PL;
            S_WR_PL: state_d = S_WR_PH;
            S_WR_PH: state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (tmr_irq) begin
                    state_d      = S_ACK;
                    tick_d       = 1'b1;
                    tick_count_d = tick_count_q + {{(TICK_W-1){1'b0}}, 1'b1};
                end else if (stop_req || stop_pend_q) begin
                    state_d     = S_HALT;
                    stop_pend_d = 1'b0;
                end
`ifdef EASY_TIMER_SEQ_SNAPSHOT_EN
                else if (snap_req_s || snap_pend_q) begin
                    state_d     = S_SNAP_W;
                    ret_run_d   = 1'b1;
                    snap_pend_d = 1'b0;
                end
`endif
                else begin
                    state_d = S_RUN;
                end
            end
            S_ACK: begin
                if (cont_q && !stop_pend_q && !stop_req) begin
                    state_d = S_RUN;
                end else begin
                    state_d     = S_HALT;
                    stop_pend_d = 1'b0;
                end
            end
            S_HALT: state_d = S_CLR;
            S_CLR:  state_d = S_IDLE;
`ifdef EASY_TIMER_SEQ_SNAPSHOT_EN
            S_SNAP_W:  state_d = S_SNAP_RL;
            S_SNAP_RL: state_d = S_SNAP_RH;
            S_SNAP_RH: begin
                // readdata now carries the low half addressed in SNAP_RL.
                snap_lo_d = tmr_readdata;
                state_d   = S_SNAP_CAP;
            end
            S_SNAP_CAP: begin
                snap_value_d = {tmr_readdata, snap_lo_q};
                snap_valid_d = 1'b1;
                if (ret_run_q) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        cfg_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        addr_d      = A_STATUS;
        cs_d        = 1'b0;
        wn_d        = 1'b1;
        wdata_d     = 16'h0000;
        // Bus signals are decoded from the upcoming state so they align with it.
        case (state_d)
            S_STOP:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CONTROL;  wdata_d = CTRL_STOP;        end
            S_WR_PL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PERIOD_L; wdata_d = period_q[15:0];   end
            S_WR_PH: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PERIOD_H; wdata_d = period_q[31:16];  end
            S_START: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = A_CONTROL;
                if (cont_q) begin
                    wdata_d = CTRL_START | CTRL_CONT;
                end else begin
                    wdata_d = CTRL_START;
                end
            end
            S_ACK:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_STATUS;   wdata_d = 16'h0000;         end
            S_HALT:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CONTROL;  wdata_d = CTRL_STOP;        end
            S_CLR:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_STATUS;   wdata_d = 16'h0000;         end
`ifdef EASY_TIMER_SEQ_SNAPSHOT_EN
            S_SNAP_W:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_SNAP_L; wdata_d = 16'h0000; end
            S_SNAP_RL: begin cs_d = 1'b1; wn_d = 1'b1; addr_d = A_SNAP_L; wdata_d = 16'h0000; end
            S_SNAP_RH: begin cs_d = 1'b1; wn_d = 1'b1; addr_d = A_SNAP_H; wdata_d = 16'h0000; end
`endif
            default: begin cs_d = 1'b0; wn_d = 1'b1; addr_d = A_STATUS; wdata_d = 16'h0000; end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            period_q     <= 32'h0000_0000;
            cont_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            ret_run_q    <= 1'b0;
            snap_lo_q    <= 16'h0000;
            snap_value_q <= 32'h0000_0000;
            snap_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= {TICK_W{1'b0}};
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            addr_q       <= 3'd0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wdata_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            ret_run_q    <= ret_run_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            wdata_q      <= wdata_d;
        end
    end

    assign cfg_ready      = cfg_ready_q;
    assign busy           = busy_q;
    assign tick           = tick_q;
    assign tick_count     = tick_count_q;
    assign snap_valid     = snap_valid_q;
    assign snap_value     = snap_value_q;
    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_writedata  = wdata_q;

endmodule

// File: doc/easy_timer_seq.md
EASY_TIMER_SEQ -- requirements
Module: easy_timer_seq

Interface
REQ-001 SHALL have parameter TICK_W, default 16, width of tick_count.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports cfg_valid in 1, cfg_ready out 1, cfg_period in 32, cfg_continuous in 1: configuration handshake.
REQ-005 SHALL have port stop_req  input  1  single-cycle stop request.
REQ-006 SHALL have port snap_req  input  1  single-cycle snapshot request.
REQ-007 SHALL have ports snap_valid out 1, snap_value out 32: snapshot result.
REQ-008 SHALL have ports tick out 1 (one-cycle timeout pulse), tick_count out TICK_W, busy out 1 (state != IDLE).
REQ-009 SHALL have timer-master ports tmr_address out 3, tmr_chipselect out 1, tmr_write_n out 1, tmr_writedata out 16, tmr_readdata in 16, tmr_irq in 1.

Function
REQ-010 SHALL assume the timer slave map: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h; zero wait states; readdata registered, valid one cycle after address.
REQ-011 SHALL use states IDLE, STOP, WR_PL, WR_PH, START, RUN, ACK, HALT, CLR, SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP; each non-IDLE/RUN state lasts exactly one cycle.
REQ-012 cfg_ready SHALL equal (state == IDLE); cfg accepted when cfg_valid && cfg_ready; period and continuous bit latched; tick_count cleared.
REQ-013 Accept SHALL sequence STOP (addr 1, data 0x0008) -> WR_PL (addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> START (addr 1, data 0x0005 | continuous<<1) -> RUN.
REQ-014 Write states SHALL drive chipselect=1, write_n=0; RUN/IDLE SHALL drive chipselect=0, write_n=1, address=0, writedata=0.
REQ-015 In RUN, tmr_irq=1 SHALL move to ACK (addr 0, data 0x0000); tick pulses and tick_count increments (mod 2^TICK_W) in the ACK cycle.
REQ-016 After ACK: RUN if continuous and no stop pending, else HALT.
REQ-017 HALT SHALL write addr 1, data 0x0008; then CLR writes addr 0, data 0; then IDLE.
REQ-018 stop_req in RUN SHALL go to HALT; stop_req while in ACK or a snapshot state SHALL latch stop_pending, serviced at next RUN decision; stop_req in IDLE or configuration states ignored.
REQ-019 RUN priority: tmr_irq > stop (req or pending) > snapshot (req or pending).
REQ-020 snap_req arriving in a non-RUN, non-IDLE state SHALL latch snap_pending; snap_req in IDLE accepted directly.
REQ-021 tmr_irq SHALL be ignored outside RUN.

Reset
REQ-022 On reset: state IDLE, cfg_ready=1, busy=0, tick=0, tick_count=0, snap_valid=0, snap_value=0, stop/snap pending=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
REQ-023 Reset mid-sequence SHALL abort at the next edge with no further timer access; timer contents are not restored.

Configuration
REQ-024 Macro EASY_TIMER_SEQ_SNAPSHOT_EN defined: snapshot sequence SNAP_W (write addr 4, data 0) -> SNAP_RL (read addr 4) -> SNAP_RH (read addr 5, capture readdata as low half) -> SNAP_CAP (capture readdata as high half) -> return state; snap_valid high one cycle after SNAP_CAP with snap_value held until next snapshot. Return state is RUN if entered from RUN, else IDLE.
REQ-025 Macro undefined: SNAP_* states absent, snap_req ignored, snap_valid=0, snap_value=0.

Verification
REQ-026 Reset, cfg_valid, period 0x0001_86A0, continuous=1 -> writes (1,0x0008),(2,0x86A0),(3,0x0001),(1,0x0007) on 4 consecutive cycles, then RUN.
REQ-027 In RUN continuous, pulse tmr_irq three times -> three ACK writes (0,0x0000), tick_count=3, return to RUN each time.
REQ-028 One-shot (continuous=0), tmr_irq -> ACK, HALT (1,0x0008), CLR (0,0), IDLE; cfg_ready=1.
REQ-029 stop_req and tmr_irq same cycle in RUN -> ACK first, tick_count+1, then HALT, CLR, IDLE.
REQ-030 SNAPSHOT_EN, timer model counter 0x0002_1234 at SNAP_W edge -> snap_valid one cycle, snap_value=0x0002_1234; without macro, snap_req produces no bus activity.
REQ-031 Reset asserted during WR_PH -> next cycle chipselect=0, state IDLE, tick_count=0.
